// File: rtl/adc_pkg.sv
// Shared definitions for the dual-channel SPI ADC capture block: FSM encoding
// and default timing parameters.
package adc_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CONV      = 3'd1,
    WAIT_BUSY = 3'd2,
    SHIFT     = 3'd3,
    DONE      = 3'd4
  } state_t;

  localparam int DATA_W           = 16;
  localparam int DEF_CLK_DIV      = 4;
  localparam int DEF_CONV_PULSE   = 8;
  localparam int DEF_BUSY_TIMEOUT = 1000;
  localparam int DEF_SAMPLE_GAP   = 100;

endpackage

// File: rtl/spi_clk_gen.sv
// SPI clock generator: after a start pulse emits BITS SCLK periods (low half
// first), flags the CLK edge that raises SCLK and the edge ending the frame.
module spi_clk_gen
  import adc_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV,
  parameter int BITS    = DATA_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  output logic sclk,
  output logic sample_en,
  output logic done
);

  localparam int DW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int BW = $clog2(BITS);

  logic          active;
  logic [DW-1:0] div_cnt;
  logic [BW-1:0] bit_cnt;
  logic          half_end;

  assign half_end  = active && (div_cnt == DW'(CLK_DIV - 1));
  assign sample_en = half_end && !sclk;
  assign done      = half_end && sclk && (bit_cnt == BW'(BITS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active  <= 1'b0;
      sclk    <= 1'b0;
      div_cnt <= '0;
      bit_cnt <= '0;
    end else if (start) begin
      active  <= 1'b1;
      sclk    <= 1'b0;
      div_cnt <= '0;
      bit_cnt <= '0;
    end else if (active) begin
      if (half_end) begin
        div_cnt <= '0;
        sclk    <= ~sclk;
        // A falling SCLK closes one bit period; the last one ends the frame.
        if (sclk) begin
          if (bit_cnt == BW'(BITS - 1)) active <= 1'b0;
          else                           bit_cnt <= bit_cnt + 1'b1;
        end
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/adc_spi_capture.sv
// Conversion sequencer for a dual-output SPI ADC: pulses CONVST, waits for
// BUSY to fall (with timeout), shifts in both channels and presents them.
module adc_spi_capture
  import adc_pkg::*;
#(
  parameter int CLK_DIV      = DEF_CLK_DIV,
  parameter int CONV_PULSE   = DEF_CONV_PULSE,
  parameter int BUSY_TIMEOUT = DEF_BUSY_TIMEOUT,
  parameter int SAMPLE_GAP   = DEF_SAMPLE_GAP
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              EN,
  output logic              ADC_CONVST,
  input  logic              ADC_BUSY,
  output logic              ADC_CS_N,
  output logic              ADC_SCLK,
  input  logic              ADC_SDO1,
  input  logic              ADC_SDO2,
  output logic [DATA_W-1:0] ADC1DAT,
  output logic [DATA_W-1:0] ADC2DAT,
  output logic              DAT_VLD,
  output logic              ERR_TO
);

  localparam int MAX_A   = (BUSY_TIMEOUT > SAMPLE_GAP) ? BUSY_TIMEOUT : SAMPLE_GAP;
  localparam int CNT_MAX = (MAX_A > CONV_PULSE) ? MAX_A : CONV_PULSE;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_t            state, next_state;
  logic [CNT_W-1:0]  tmr;
  logic [CNT_W-1:0]  gap_cnt;
  logic              busy_s1, busy_s2, busy_s3;
  logic              busy_fall, fell_seen;
  logic              err_next, start, sample_en, spi_done;
  logic [DATA_W-1:0] sreg1, sreg2;

  assign busy_fall = busy_s3 && !busy_s2;
  assign start     = (state == WAIT_BUSY) && (next_state == SHIFT);

  always_comb begin
    next_state = state;
    err_next   = 1'b0;
    case (state)
      IDLE:
        if (EN && (gap_cnt >= CNT_W'(SAMPLE_GAP - 1))) next_state = CONV;
      CONV:
        if (tmr == CNT_W'(CONV_PULSE - 1)) next_state = WAIT_BUSY;
      WAIT_BUSY:
        if (busy_fall || fell_seen) begin
          next_state = SHIFT;
        end else if (tmr >= CNT_W'(BUSY_TIMEOUT - 1)) begin
          next_state = IDLE;
          err_next   = 1'b1;
        end
      SHIFT:
        if (spi_done) next_state = DONE;
      DONE:
        next_state = IDLE;
      default:
        next_state = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they never glitch.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state      <= IDLE;
      ADC_CONVST <= 1'b0;
      ADC_CS_N   <= 1'b1;
      ERR_TO     <= 1'b0;
      tmr        <= '0;
      gap_cnt    <= CNT_W'(SAMPLE_GAP - 1);
      fell_seen  <= 1'b0;
    end else begin
      state      <= next_state;
      ADC_CONVST <= (next_state == CONV);
      ADC_CS_N   <= (next_state != SHIFT);
      ERR_TO     <= err_next;
      if (state == IDLE && next_state == CONV) tmr <= '0;
      else if (state == CONV || state == WAIT_BUSY) tmr <= tmr + 1'b1;
      if (state == IDLE && next_state == CONV) gap_cnt <= '0;
      else if (gap_cnt != CNT_W'(SAMPLE_GAP - 1)) gap_cnt <= gap_cnt + 1'b1;
      // A BUSY fall already seen during the CONVST pulse must not be lost.
      if (state == IDLE) fell_seen <= 1'b0;
      else if (state == CONV && busy_fall) fell_seen <= 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      busy_s1 <= 1'b0;
      busy_s2 <= 1'b0;
      busy_s3 <= 1'b0;
    end else begin
      busy_s1 <= ADC_BUSY;
      busy_s2 <= busy_s1;
      busy_s3 <= busy_s2;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sreg1   <= '0;
      sreg2   <= '0;
      ADC1DAT <= '0;
      ADC2DAT <= '0;
      DAT_VLD <= 1'b0;
    end else begin
      if (sample_en) begin
        sreg1 <= {sreg1[DATA_W-2:0], ADC_SDO1};
        sreg2 <= {sreg2[DATA_W-2:0], ADC_SDO2};
      end
      DAT_VLD <= (state == SHIFT) && spi_done;
      if (state == SHIFT && spi_done) begin
        ADC1DAT <= sreg1;
        ADC2DAT <= sreg2;
      end
    end
  end

  spi_clk_gen #(
    .CLK_DIV(CLK_DIV),
    .BITS   (DATA_W)
  ) u_spi_clk_gen (
    .clk      (CLK),
    .rst_n    (RST_N),
    .start    (start),
    .sclk     (ADC_SCLK),
    .sample_en(sample_en),
    .done     (spi_done)
  );

endmodule

// File: tb/tb_adc_spi_capture.sv
// Directed bench for adc_spi_capture: ADC BUSY/SDO responders, frame monitors,
// table-driven data frames and hand-written timeout/EN-drop/reset sequences.
module tb_adc_spi_capture;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, en, busy, sdo1, sdo2;
  logic        convst, cs_n, sclk, vld, err_to;
  logic [15:0] dat1, dat2;

  logic        rst2_n, en2, busy2, sdo21, sdo22;
  logic        convst2, cs2_n, sclk2, vld2, err2;
  logic [15:0] dat21, dat22;

  adc_spi_capture dut (
    .CLK(clk), .RST_N(rst_n), .EN(en), .ADC_CONVST(convst), .ADC_BUSY(busy),
    .ADC_CS_N(cs_n), .ADC_SCLK(sclk), .ADC_SDO1(sdo1), .ADC_SDO2(sdo2),
    .ADC1DAT(dat1), .ADC2DAT(dat2), .DAT_VLD(vld), .ERR_TO(err_to)
  );

  adc_spi_capture #(.CLK_DIV(2)) dut2 (
    .CLK(clk), .RST_N(rst2_n), .EN(en2), .ADC_CONVST(convst2), .ADC_BUSY(busy2),
    .ADC_CS_N(cs2_n), .ADC_SCLK(sclk2), .ADC_SDO1(sdo21), .ADC_SDO2(sdo22),
    .ADC1DAT(dat21), .ADC2DAT(dat22), .DAT_VLD(vld2), .ERR_TO(err2)
  );

  typedef struct {
    logic [15:0] sdo1;
    logic [15:0] sdo2;
    logic [15:0] exp1;
    logic [15:0] exp2;
  } vec_t;

  vec_t        tab [5];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [15:0] pat1 = '0, pat2 = '0;
  int          busy_mode = 0;

  // monitor / responder state
  int rises = 0, bad_per = 0, last_rise = -1;
  int vld_cnt = 0, bad_vld = 0, cv_rises = 0, last_cv = -1, bad_gap = 0;
  int err_cnt = 0, err_cyc = 0, cv_cyc = 0, busy_left = 0, bidx = 15;
  bit sclk_q = 0, vld_q = 0, cv_q = 0;
  int rises2 = 0, bad_per2 = 0, last_rise2 = -1, busy_left2 = 0, bidx2 = 15;
  bit sclk2_q = 0, cv2_q = 0;

  always @(posedge clk) cyc = cyc + 1;

  always @(negedge clk) begin
    if (cs_n) last_rise = -1;
    if (sclk && !sclk_q) begin
      rises++;
      if (last_rise >= 0 && cyc - last_rise != 8) bad_per++;
      last_rise = cyc;
    end
    if (cs_n) bidx = 15;
    else if (!sclk && sclk_q && bidx > 0) bidx--;
    sclk_q = sclk;
    sdo1 = pat1[bidx];
    sdo2 = pat2[bidx];
    if (vld) begin
      vld_cnt++;
      if (vld_q) bad_vld++;
    end
    vld_q = vld;
    if (!rst_n) last_cv = -1;
    if (busy_left > 0) begin
      busy_left--;
      if (busy_left == 0) busy = 1'b0;
    end
    if (convst && !cv_q) begin
      cv_rises++;
      if (last_cv >= 0 && cyc - last_cv < 100) bad_gap++;
      last_cv = cyc;
      cv_cyc  = cyc;
      if (busy_mode == 0) begin
        busy      = 1'b1;
        busy_left = 20;
      end
    end
    cv_q = convst;
    if (err_to) begin
      err_cnt++;
      err_cyc = cyc;
    end
    // second instance (CLK_DIV=2)
    if (cs2_n) last_rise2 = -1;
    if (sclk2 && !sclk2_q) begin
      rises2++;
      if (last_rise2 >= 0 && cyc - last_rise2 != 4) bad_per2++;
      last_rise2 = cyc;
    end
    if (cs2_n) bidx2 = 15;
    else if (!sclk2 && sclk2_q && bidx2 > 0) bidx2--;
    sclk2_q = sclk2;
    sdo21 = pat1[bidx2];
    sdo22 = pat2[bidx2];
    if (busy_left2 > 0) begin
      busy_left2--;
      if (busy_left2 == 0) busy2 = 1'b0;
    end
    if (convst2 && !cv2_q) begin
      busy2      = 1'b1;
      busy_left2 = 20;
    end
    cv2_q = convst2;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_vld(input string name, input int maxc);
    bit ok = 0;
    for (int i = 0; i < maxc; i++) begin
      tick();
      if (vld) begin
        ok = 1;
        break;
      end
    end
    chk(name, {31'd0, ok}, 32'd1);
  endtask

  task automatic wait_rises(input string name, input int target, input int maxc);
    bit ok = 0;
    for (int i = 0; i < maxc; i++) begin
      tick();
      if (rises >= target) begin
        ok = 1;
        break;
      end
    end
    chk(name, {31'd0, ok}, 32'd1);
  endtask

  int base_r, base_v, base_c;
  bit seen;

  initial begin
    tab[0] = '{16'h0000, 16'hFFFF, 16'h0000, 16'hFFFF};
    tab[1] = '{16'hFFFF, 16'h0000, 16'hFFFF, 16'h0000};
    tab[2] = '{16'h1234, 16'hEDCB, 16'h1234, 16'hEDCB};
    tab[3] = '{16'hA5A5, 16'h5A5A, 16'hA5A5, 16'h5A5A};
    tab[4] = '{16'h8000, 16'h7FFF, 16'h8000, 16'h7FFF};

    rst_n = 1'b0; en = 1'b0; busy = 1'b0;
    rst2_n = 1'b0; en2 = 1'b0; busy2 = 1'b0;
    repeat (5) tick();
    chk("rst_convst", {31'd0, convst}, 32'd0);
    chk("rst_cs_n", {31'd0, cs_n}, 32'd1);
    chk("rst_sclk", {31'd0, sclk}, 32'd0);
    chk("rst_dat1", {16'd0, dat1}, 32'd0);
    chk("rst_dat2", {16'd0, dat2}, 32'd0);
    chk("rst_vld", {31'd0, vld}, 32'd0);
    chk("rst_err", {31'd0, err_to}, 32'd0);

    // Basic frame; EN drops during CONV so only this frame runs.
    rst_n = 1'b1;
    tick();
    pat1 = 16'h8001; pat2 = 16'h7FFE;
    base_r = rises;
    en = 1'b1;
    tick();
    chk("first_convst", {31'd0, convst}, 32'd1);
    chk("conv_cs_n", {31'd0, cs_n}, 32'd1);
    en = 1'b0;
    wait_vld("basic_vld_seen", 400);
    chk("basic_dat1", {16'd0, dat1}, 32'h8001);
    chk("basic_dat2", {16'd0, dat2}, 32'h7FFE);
    chk("basic_rises", rises - base_r, 32'd16);
    chk("basic_period", bad_per, 32'd0);
    tick();
    chk("basic_vld_width", {31'd0, vld}, 32'd0);
    chk("basic_idle_sclk", {31'd0, sclk}, 32'd0);
    base_c = cv_rises;
    repeat (200) tick();
    chk("en_low_no_convst", cv_rises - base_c, 32'd0);

    // BUSY stuck low -> timeout
    busy_mode = 1;
    base_v = vld_cnt;
    en = 1'b1;
    tick();
    chk("to_convst", {31'd0, convst}, 32'd1);
    seen = 0;
    for (int i = 0; i < 1100; i++) begin
      tick();
      if (err_to) begin
        seen = 1;
        break;
      end
    end
    chk("to_seen", {31'd0, seen}, 32'd1);
    chk("to_latency", err_cyc - cv_cyc, 32'd1000);
    chk("to_dat1_kept", {16'd0, dat1}, 32'h8001);
    chk("to_dat2_kept", {16'd0, dat2}, 32'h7FFE);
    chk("to_no_vld", vld_cnt - base_v, 32'd0);
    busy_mode = 0;
    pat1 = tab[0].sdo1; pat2 = tab[0].sdo2;
    tick();
    chk("to_width", {31'd0, err_to}, 32'd0);

    // Continuous frames from the vector table
    for (int i = 0; i < 5; i++) begin
      pat1 = tab[i].sdo1; pat2 = tab[i].sdo2;
      wait_vld($sformatf("vec%0d_vld_seen", i), 400);
      chk($sformatf("vec%0d_dat1", i), {16'd0, dat1}, {16'd0, tab[i].exp1});
      chk($sformatf("vec%0d_dat2", i), {16'd0, dat2}, {16'd0, tab[i].exp2});
    end
    chk("vec_vld_count", vld_cnt - base_v, 32'd5);
    chk("vec_vld_single", bad_vld, 32'd0);
    chk("convst_gap", bad_gap, 32'd0);
    chk("err_total", err_cnt, 32'd1);

    // EN dropped mid-SHIFT: frame completes, then nothing more
    pat1 = 16'h00FF; pat2 = 16'hFF00;
    base_r = rises;
    wait_rises("endrop_reach_bit8", base_r + 8, 400);
    en = 1'b0;
    wait_vld("endrop_vld_seen", 300);
    chk("endrop_dat1", {16'd0, dat1}, 32'h00FF);
    chk("endrop_dat2", {16'd0, dat2}, 32'hFF00);
    base_c = cv_rises;
    repeat (300) tick();
    chk("endrop_no_convst", cv_rises - base_c, 32'd0);

    // Reset mid-SHIFT abandons the frame
    pat1 = 16'h1111; pat2 = 16'h2222;
    en = 1'b1;
    base_r = rises;
    wait_rises("rst_reach_bit5", base_r + 5, 400);
    base_v = vld_cnt;
    rst_n = 1'b0;
    #1;
    chk("midrst_cs_n", {31'd0, cs_n}, 32'd1);
    chk("midrst_sclk", {31'd0, sclk}, 32'd0);
    chk("midrst_dat1", {16'd0, dat1}, 32'd0);
    chk("midrst_dat2", {16'd0, dat2}, 32'd0);
    chk("midrst_vld", {31'd0, vld}, 32'd0);
    repeat (3) tick();
    chk("midrst_no_vld", vld_cnt - base_v, 32'd0);
    pat1 = 16'h4321; pat2 = 16'hBCDE;
    rst_n = 1'b1;
    wait_vld("restart_vld_seen", 400);
    chk("restart_dat1", {16'd0, dat1}, 32'h4321);
    chk("restart_dat2", {16'd0, dat2}, 32'hBCDE);
    chk("restart_vld_count", vld_cnt - base_v, 32'd1);
    en = 1'b0;

    // CLK_DIV = 2 instance
    repeat (5) tick();
    pat1 = 16'h8001; pat2 = 16'h7FFE;
    rst2_n = 1'b1;
    en2 = 1'b1;
    seen = 0;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (vld2) begin
        seen = 1;
        break;
      end
    end
    en2 = 1'b0;
    chk("div2_vld_seen", {31'd0, seen}, 32'd1);
    chk("div2_dat1", {16'd0, dat21}, 32'h8001);
    chk("div2_dat2", {16'd0, dat22}, 32'h7FFE);
    chk("div2_rises", rises2, 32'd16);
    chk("div2_period", bad_per2, 32'd0);
    tick();
    chk("div2_vld_width", {31'd0, vld2}, 32'd0);
    chk("div2_err", {31'd0, err2}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
